// File: rtl/ay_pkg.sv
// Shared types and constants for the AY-3-8500 paddle front end.
package ay_pkg;

   typedef enum logic [1:0] {
      PM_DIGITAL  = 2'd0,
      PM_ANALOG_Y = 2'd1,
      PM_ANALOG_X = 2'd2,
      PM_PADDLE   = 2'd3
   } paddle_mode_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } timer_state_t;

   localparam logic [8:0] POS_MAX = 9'd255;
   localparam logic [8:0] POS_MIN = 9'd0;

endpackage

// File: rtl/rise_edge.sv
// One-bit rising-edge detector; the history flop updates every cycle.
module rise_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);

   logic d_old_q;
   logic d_old_d;

   always_comb begin
      d_old_d = d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) d_old_q <= 1'b0;
      else        d_old_q <= d_old_d;
   end

   assign rise = d & ~d_old_q;

endmodule

// File: rtl/ay_paddle_timer.sv
// One player's paddle timer: latches a line count on each frame and counts
// it down per line; pin_in goes high once the count has run out.
module ay_paddle_timer
   import ay_pkg::*;
#(
   parameter int POS_INIT  = 128,
   parameter int STEP_SLOW = 5,
   parameter int STEP_FAST = 8
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        hs,
   input  logic        vs,
   input  logic [1:0]  mode,
   input  logic        invert,
   input  logic        speed,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic [15:0] analog,
   input  logic [7:0]  paddle,
   output logic        pin_in,
   output logic [7:0]  pos,
   output logic        frame_valid
);

   logic         hs_rise, vs_rise;
   logic [8:0]   pos_q, pos_d;
   logic [8:0]   cap_q, cap_d;
   timer_state_t state_q, state_d;
   logic [7:0]   cap_src, cap_new;
   logic [8:0]   step, pos_sub, pos_add;

   rise_edge u_hs_edge (.clk(clk_sys), .rst_n(reset), .d(hs), .rise(hs_rise));
   rise_edge u_vs_edge (.clk(clk_sys), .rst_n(reset), .d(vs), .rise(vs_rise));

   always_comb begin
      // Analog axes are signed; flipping the MSB maps -128..127 onto 0..255.
      case (paddle_mode_t'(mode))
         PM_DIGITAL:  cap_src = pos_q[7:0];
         PM_ANALOG_Y: cap_src = {~analog[15], analog[14:8]};
         PM_ANALOG_X: cap_src = {~analog[7], analog[6:0]};
         default:     cap_src = paddle;
      endcase
      cap_new = cap_src ^ {8{invert}};

      step    = speed ? 9'(STEP_FAST) : 9'(STEP_SLOW);
      pos_sub = pos_q - step;
      pos_add = pos_q + step;

      pos_d   = pos_q;
      cap_d   = cap_q;
      state_d = state_q;

      if (vs_rise) begin
         cap_d   = {1'b0, cap_new};
         state_d = (cap_new == 8'd0) ? DONE : COUNT;
         if (paddle_mode_t'(mode) == PM_DIGITAL) begin
            // 9-bit subtraction wraps past 255 on underflow.
            if (btn_down)    pos_d = (pos_add > POS_MAX) ? POS_MAX : pos_add;
            else if (btn_up) pos_d = (pos_sub > POS_MAX) ? POS_MIN : pos_sub;
         end
      end else if (hs_rise && cap_q != 9'd0) begin
         cap_d = cap_q - 9'd1;
         if (state_q == COUNT && cap_q == 9'd1) state_d = DONE;
      end
   end

   always_ff @(posedge clk_sys or negedge reset) begin
      if (!reset) begin
         pos_q   <= 9'(POS_INIT);
         cap_q   <= 9'd0;
         state_q <= IDLE;
      end else begin
         pos_q   <= pos_d;
         cap_q   <= cap_d;
         state_q <= state_d;
      end
   end

   assign pin_in      = (cap_q == 9'd0);
   assign pos         = pos_q[7:0];
   assign frame_valid = (state_q != IDLE);

endmodule

// File: tb/tb_ay_paddle_timer.sv
// Directed bench for ay_paddle_timer; expected values are hand-derived.
module tb_ay_paddle_timer;
   import ay_pkg::*;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b0;
   logic        hs = 1'b0, vs = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic        invert = 1'b0, speed = 1'b0;
   logic        btn_up = 1'b0, btn_down = 1'b0;
   logic [15:0] analog = 16'h0000;
   logic [7:0]  paddle = 8'd0;
   logic        pin_in;
   logic [7:0]  pos;
   logic        frame_valid;

   int n_chk = 0;
   int n_fail = 0;
   int pin_hi_cnt = 0;

   ay_paddle_timer dut (
      .clk_sys(clk_sys), .reset(reset), .hs(hs), .vs(vs), .mode(mode),
      .invert(invert), .speed(speed), .btn_up(btn_up), .btn_down(btn_down),
      .analog(analog), .paddle(paddle), .pin_in(pin_in), .pos(pos),
      .frame_valid(frame_valid)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; pin_in high samples are tallied there too.
   task automatic tick();
      @(negedge clk_sys);
      if (pin_in) pin_hi_cnt++;
   endtask

   task automatic hs_n(input int n);
      for (int i = 0; i < n; i++) begin
         hs = 1'b1; tick();
         hs = 1'b0; tick();
      end
   endtask

   task automatic vs_pulse();
      vs = 1'b1; tick();
      vs = 1'b0; tick();
   endtask

   initial begin
      int exp_pos;
      tick();
      // 1: reset values, then a digital count from POS_INIT
      chk("rst_pin", pin_in, 1);
      chk("rst_pos", pos, 128);
      chk("rst_fv", frame_valid, 0);
      reset = 1'b1; tick();
      chk("idle_fv", frame_valid, 0);
      vs_pulse();
      chk("t1_pin_lo", pin_in, 0);
      chk("t1_cap", dut.cap_q, 128);
      chk("t1_fv", frame_valid, 1);
      hs_n(127);
      chk("t1_pin_127", pin_in, 0);
      hs_n(1);
      chk("t1_pin_128", pin_in, 1);
      chk("t1_state", 32'(dut.state_q), 32'(DONE));
      hs_n(72);
      chk("t1_cap_hold", dut.cap_q, 0);
      chk("t1_pos", pos, 128);

      // 2: stepping with saturation at both ends
      btn_up = 1'b1; speed = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         vs_pulse();
         exp_pos = 128 - 5 * k;
         if (exp_pos < 0) exp_pos = 0;
         chk($sformatf("t2_up%0d", k), pos, exp_pos);
      end
      btn_up = 1'b0; btn_down = 1'b1; speed = 1'b1;
      for (int k = 1; k <= 35; k++) begin
         vs_pulse();
         exp_pos = 8 * k;
         if (exp_pos > 255) exp_pos = 255;
         chk($sformatf("t2_dn%0d", k), pos, exp_pos);
      end
      btn_up = 1'b1;
      vs_pulse();
      chk("t2_both", pos, 255);
      btn_up = 1'b0; btn_down = 1'b0;

      // 3: analog Y capture and inversion
      mode = 2'd1; analog = 16'h8000;
      vs_pulse();
      chk("t3_zero_pin", pin_in, 1);
      chk("t3_zero_state", 32'(dut.state_q), 32'(DONE));
      analog = 16'h7F00;
      vs_pulse();
      chk("t3_max_cap", dut.cap_q, 255);
      hs_n(254);
      chk("t3_max_254", pin_in, 0);
      hs_n(1);
      chk("t3_max_255", pin_in, 1);
      invert = 1'b1;
      vs_pulse();
      chk("t3_inv_cap", dut.cap_q, 0);
      chk("t3_inv_pin", pin_in, 1);
      invert = 1'b0;
      mode = 2'd2; analog = 16'h0005;
      vs_pulse();
      chk("t3_x_cap", dut.cap_q, 133);

      // 4: coincident vs/hs, vs wins
      mode = 2'd3; paddle = 8'd10;
      vs = 1'b1; hs = 1'b1; tick();
      vs = 1'b0; hs = 1'b0; tick();
      chk("t4_cap", dut.cap_q, 10);
      hs_n(9);
      chk("t4_pin_9", pin_in, 0);
      hs_n(1);
      chk("t4_pin_10", pin_in, 1);

      // 5: reload mid-count without pin_in pulsing
      paddle = 8'd200;
      vs_pulse();
      pin_hi_cnt = 0;
      hs_n(50);
      chk("t5_cap50", dut.cap_q, 150);
      paddle = 8'd30;
      vs_pulse();
      chk("t5_reload", dut.cap_q, 30);
      hs_n(29);
      chk("t5_no_pulse", pin_hi_cnt, 0);
      hs_n(1);
      chk("t5_pin_30", pin_in, 1);

      // 6: asynchronous reset mid-count
      paddle = 8'd200;
      vs_pulse();
      hs_n(123);
      chk("t6_cap77", dut.cap_q, 77);
      chk("t6_pos_pre", pos, 255);
      #2 reset = 1'b0;
      #1;
      chk("t6_rst_pin", pin_in, 1);
      chk("t6_rst_pos", pos, 128);
      chk("t6_rst_fv", frame_valid, 0);
      tick();
      reset = 1'b1; tick();
      chk("t6_rel_fv", frame_valid, 0);
      vs_pulse();
      chk("t6_vs_fv", frame_valid, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
